// File: rtl/warp_mask_sequencer.sv
// SIMT divergence sequencer: tracks the active lane-group code of an 8-lane warp on a 4-entry stack.
// Optional event counters are built when WARP_MASK_SEQ_STATS_EN is defined; otherwise they read 0.
module warp_mask_sequencer #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic [PC_W-1:0] div_taken_pc,
  input  logic [PC_W-1:0] div_reconv_pc,
  input  logic            rc_valid,
  output logic [3:0]      threads_mask,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [2:0]      stack_depth,
  output logic            div_err,
  output logic            rc_err,
  output logic [15:0]     div_count,
  output logic [15:0]     rc_count
);

  localparam logic [3:0] CodeFull  = 4'b0000;
  localparam logic [3:0] CodeLoHalf = 4'b1000;
  localparam logic [3:0] CodeHiHalf = 4'b1010;
  localparam logic [3:0] CodePair0 = 4'b1100;
  localparam logic [3:0] CodePair1 = 4'b1101;
  localparam logic [3:0] CodePair2 = 4'b1110;
  localparam logic [3:0] CodePair3 = 4'b1111;

  logic [3:0]      code_q, code_d;
  logic [2:0]      depth_q, depth_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            div_err_q, div_err_d;
  logic            rc_err_q, rc_err_d;

  logic [3:0]      stk_code [4];
  logic [PC_W-1:0] stk_pc   [4];

  logic [3:0] lower_code, sibling_code;
  logic       can_div;
  logic       accept, div_bad, pop, rc_bad;
  logic [1:0] push_lo_idx, push_hi_idx, top_idx;

  // Only full and half groups can split; pairs are the finest granularity.
  always_comb begin
    lower_code   = code_q;
    sibling_code = code_q;
    can_div      = 1'b0;
    case (code_q)
      CodeFull: begin
        lower_code   = CodeLoHalf;
        sibling_code = CodeHiHalf;
        can_div      = 1'b1;
      end
      CodeLoHalf: begin
        lower_code   = CodePair0;
        sibling_code = CodePair1;
        can_div      = 1'b1;
      end
      CodeHiHalf: begin
        lower_code   = CodePair2;
        sibling_code = CodePair3;
        can_div      = 1'b1;
      end
      default: begin
        lower_code   = code_q;
        sibling_code = code_q;
        can_div      = 1'b0;
      end
    endcase
  end

  // A pop always wins over a coincident divergence, which is then silently dropped.
  assign div_ready = div_valid & ~rc_valid & can_div;
  assign accept    = div_ready;
  assign div_bad   = div_valid & ~rc_valid & ~can_div;
  assign pop       = rc_valid & (depth_q != 3'd0);
  assign rc_bad    = rc_valid & (depth_q == 3'd0);

  assign push_lo_idx = depth_q[1:0];
  assign push_hi_idx = depth_q[1:0] + 2'd1;
  assign top_idx     = depth_q[1:0] - 2'd1;

  always_comb begin
    code_d           = code_q;
    depth_d          = depth_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    div_err_d        = 1'b0;
    rc_err_d         = 1'b0;
    if (pop) begin
      code_d           = stk_code[top_idx];
      redirect_pc_d    = stk_pc[top_idx];
      redirect_valid_d = 1'b1;
      depth_d          = depth_q - 3'd1;
    end else if (rc_bad) begin
      rc_err_d = 1'b1;
    end else if (accept) begin
      code_d  = lower_code;
      depth_d = depth_q + 3'd2;
    end else if (div_bad) begin
      div_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q           <= CodeFull;
      depth_q          <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      div_err_q        <= 1'b0;
      rc_err_q         <= 1'b0;
    end else begin
      code_q           <= code_d;
      depth_q          <= depth_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      div_err_q        <= div_err_d;
      rc_err_q         <= rc_err_d;
    end
  end

  // Stack storage is not reset; depth_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      stk_code[push_lo_idx] <= code_q;
      stk_pc[push_lo_idx]   <= div_reconv_pc;
      stk_code[push_hi_idx] <= sibling_code;
      stk_pc[push_hi_idx]   <= div_taken_pc;
    end
  end

  assign threads_mask   = code_q;
  assign stack_depth    = depth_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign div_err        = div_err_q;
  assign rc_err         = rc_err_q;

`ifdef WARP_MASK_SEQ_STATS_EN
  logic [15:0] div_count_q, rc_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_count_q <= 16'd0;
      rc_count_q  <= 16'd0;
    end else begin
      if (accept && (div_count_q != 16'hFFFF)) begin
        div_count_q <= div_count_q + 16'd1;
      end
      if (pop && (rc_count_q != 16'hFFFF)) begin
        rc_count_q <= rc_count_q + 16'd1;
      end
    end
  end

  assign div_count = div_count_q;
  assign rc_count  = rc_count_q;
`else
  assign div_count = 16'd0;
  assign rc_count  = 16'd0;
`endif

endmodule

// File: tb/tb_warp_mask_sequencer.sv
// Directed bench for warp_mask_sequencer; expected results are queued at drive time and
// compared one cycle later. Counter expectations follow WARP_MASK_SEQ_STATS_EN.
module tb_warp_mask_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_valid;
  logic        div_ready;
  logic [7:0]  div_taken_pc;
  logic [7:0]  div_reconv_pc;
  logic        rc_valid;
  logic [3:0]  threads_mask;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [2:0]  stack_depth;
  logic        div_err;
  logic        rc_err;
  logic [15:0] div_count;
  logic [15:0] rc_count;

  int checks = 0;
  int errors = 0;
  int m_div  = 0;
  int m_rc   = 0;

  typedef struct packed {
    logic [3:0]  code;
    logic [2:0]  depth;
    logic        rv;
    logic [7:0]  rpc;
    logic        derr;
    logic        rerr;
    logic [15:0] dc;
    logic [15:0] rc;
  } exp_t;

  exp_t sb[$];

  warp_mask_sequencer #(.PC_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .div_valid     (div_valid),
    .div_ready     (div_ready),
    .div_taken_pc  (div_taken_pc),
    .div_reconv_pc (div_reconv_pc),
    .rc_valid      (rc_valid),
    .threads_mask  (threads_mask),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stack_depth   (stack_depth),
    .div_err       (div_err),
    .rc_err        (rc_err),
    .div_count     (div_count),
    .rc_count      (rc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef WARP_MASK_SEQ_STATS_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic compare_out(input string tag, input exp_t e);
    check({tag, ".mask"},   {28'd0, threads_mask},   {28'd0, e.code});
    check({tag, ".depth"},  {29'd0, stack_depth},    {29'd0, e.depth});
    check({tag, ".rv"},     {31'd0, redirect_valid}, {31'd0, e.rv});
    check({tag, ".rpc"},    {24'd0, redirect_pc},    {24'd0, e.rpc});
    check({tag, ".derr"},   {31'd0, div_err},        {31'd0, e.derr});
    check({tag, ".rerr"},   {31'd0, rc_err},         {31'd0, e.rerr});
    check({tag, ".dcnt"},   {16'd0, div_count},      {16'd0, e.dc});
    check({tag, ".rcnt"},   {16'd0, rc_count},       {16'd0, e.rc});
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input string tag, input logic dv, input logic rv,
                      input logic [7:0] tk, input logic [7:0] rp, input logic rdy,
                      input logic [3:0] code, input logic [2:0] depth, input logic rvld,
                      input logic [7:0] rpc, input logic derr, input logic rerr);
    exp_t e;
    div_valid     = dv;
    rc_valid      = rv;
    div_taken_pc  = tk;
    div_reconv_pc = rp;
    #1;
    check({tag, ".ready"}, {31'd0, div_ready}, {31'd0, rdy});
    if (rdy) m_div++;
    if (rvld) m_rc++;
    e = '{code: code, depth: depth, rv: rvld, rpc: rpc, derr: derr, rerr: rerr,
          dc: cnt_exp(m_div), rc: cnt_exp(m_rc)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    rc_valid  = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb observed empty expected entry", tag);
    end else begin
      compare_out(tag, sb.pop_front());
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    div_valid     = 1'b0;
    rc_valid      = 1'b0;
    div_taken_pc  = 8'h00;
    div_reconv_pc = 8'h00;
    #1;
    compare_out("rst", '{code: 4'b0000, depth: 3'd0, rv: 1'b0, rpc: 8'h00, derr: 1'b0,
                         rerr: 1'b0, dc: 16'd0, rc: 16'd0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("idle",  0, 0, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0);
    // Single divergence and reconvergence.
    step("div1",  1, 0, 8'h20, 8'h40, 1, 4'b1000, 3'd2, 0, 8'h00, 0, 0);
    step("rc1a",  0, 1, 8'h00, 8'h00, 0, 4'b1010, 3'd1, 1, 8'h20, 0, 0);
    step("rc1b",  0, 1, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 1, 8'h40, 0, 0);
    step("hold",  0, 0, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 0, 8'h40, 0, 0);
    // Nested divergence to depth 4 and unwind.
    step("div2a", 1, 0, 8'h20, 8'h40, 1, 4'b1000, 3'd2, 0, 8'h40, 0, 0);
    step("div2b", 1, 0, 8'h30, 8'h38, 1, 4'b1100, 3'd4, 0, 8'h40, 0, 0);
    step("rc2a",  0, 1, 8'h00, 8'h00, 0, 4'b1101, 3'd3, 1, 8'h30, 0, 0);
    step("rc2b",  0, 1, 8'h00, 8'h00, 0, 4'b1000, 3'd2, 1, 8'h38, 0, 0);
    step("rc2c",  0, 1, 8'h00, 8'h00, 0, 4'b1010, 3'd1, 1, 8'h20, 0, 0);
    step("rc2d",  0, 1, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 1, 8'h40, 0, 0);
    // Illegal divergence at a pair code.
    step("div3a", 1, 0, 8'h20, 8'h40, 1, 4'b1000, 3'd2, 0, 8'h40, 0, 0);
    step("div3b", 1, 0, 8'h30, 8'h38, 1, 4'b1100, 3'd4, 0, 8'h40, 0, 0);
    step("derr",  1, 0, 8'h77, 8'h66, 0, 4'b1100, 3'd4, 0, 8'h40, 1, 0);
    step("derr0", 0, 0, 8'h00, 8'h00, 0, 4'b1100, 3'd4, 0, 8'h40, 0, 0);
    step("rc3a",  0, 1, 8'h00, 8'h00, 0, 4'b1101, 3'd3, 1, 8'h30, 0, 0);
    step("rc3b",  0, 1, 8'h00, 8'h00, 0, 4'b1000, 3'd2, 1, 8'h38, 0, 0);
    step("rc3c",  0, 1, 8'h00, 8'h00, 0, 4'b1010, 3'd1, 1, 8'h20, 0, 0);
    step("rc3d",  0, 1, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 1, 8'h40, 0, 0);
    // Pop on empty stack.
    step("rerr",  0, 1, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 0, 8'h40, 0, 1);
    step("rerr0", 0, 0, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 0, 8'h40, 0, 0);
    // Coincident divergence and pop: only the pop happens.
    step("div4",  1, 0, 8'h20, 8'h40, 1, 4'b1000, 3'd2, 0, 8'h40, 0, 0);
    step("both",  1, 1, 8'h55, 8'h56, 0, 4'b1010, 3'd1, 1, 8'h20, 0, 0);
    // Divergence at the upper half, then unwind.
    step("div5",  1, 0, 8'h50, 8'h58, 1, 4'b1110, 3'd3, 0, 8'h20, 0, 0);
    step("rc5a",  0, 1, 8'h00, 8'h00, 0, 4'b1111, 3'd2, 1, 8'h50, 0, 0);
    step("rc5b",  0, 1, 8'h00, 8'h00, 0, 4'b1010, 3'd1, 1, 8'h58, 0, 0);
    step("rc5c",  0, 1, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 1, 8'h40, 0, 0);
    // Asynchronous reset mid-nesting at depth 4.
    step("div6a", 1, 0, 8'h20, 8'h40, 1, 4'b1000, 3'd2, 0, 8'h40, 0, 0);
    step("div6b", 1, 0, 8'h30, 8'h38, 1, 4'b1100, 3'd4, 0, 8'h40, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    compare_out("arst", '{code: 4'b0000, depth: 3'd0, rv: 1'b0, rpc: 8'h00, derr: 1'b0,
                          rerr: 1'b0, dc: 16'd0, rc: 16'd0});
    m_div = 0;
    m_rc  = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("idle2", 0, 0, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 0);
    step("rc7",   0, 1, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 0, 8'h00, 0, 1);
    step("div7",  1, 0, 8'h24, 8'h48, 1, 4'b1000, 3'd2, 0, 8'h00, 0, 0);
    step("rc7a",  0, 1, 8'h00, 8'h00, 0, 4'b1010, 3'd1, 1, 8'h24, 0, 0);
    step("rc7b",  0, 1, 8'h00, 8'h00, 0, 4'b0000, 3'd0, 1, 8'h48, 0, 0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_drain observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
